// File: rtl/mult_seq_ctrl_pkg.sv
// Shared encodings for the shift-and-add multiplier sequencer: FSM states
// and the control codes understood by the external Q shift register.
package mult_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Q shift-register control codes (its ctrl pins).
    localparam logic [1:0] CTRL_HOLD = 2'b00;
    localparam logic [1:0] CTRL_SHR  = 2'b01;
    localparam logic [1:0] CTRL_SHL  = 2'b10;
    localparam logic [1:0] CTRL_LOAD = 2'b11;

endpackage : mult_seq_ctrl_pkg

// File: rtl/mult_seq_ctrl_if.sv
// Bus between the multiplier sequencer and its environment: start/done
// handshake, operands, product, and the pins of the external Q register.
// master = requester plus Q register side, slave = the sequencer.
interface mult_seq_ctrl_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic [WIDTH-1:0]       a_in;
    logic [WIDTH-1:0]       b_in;
    logic [WIDTH-1:0]       q_in;
    logic [1:0]             q_ctrl;
    logic                   q_sinr;
    logic                   q_sinl;
    logic [WIDTH-1:0]       q_data;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, a_in, b_in, q_in,
        input  q_ctrl, q_sinr, q_sinl, q_data, busy, done, product
    );

    modport slave (
        input  start, a_in, b_in, q_in,
        output q_ctrl, q_sinr, q_sinl, q_data, busy, done, product
    );
endinterface : mult_seq_ctrl_if

// File: rtl/mult_seq_ctrl_add_step.sv
// One add step of the shift-and-add multiplier: adds the multiplicand to
// the high product half when the current multiplier bit is set. The extra
// MSB keeps the carry so it shifts back into A without overflow.
module mult_add_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] mcand_i,
    input  logic             add_en_i,
    output logic [WIDTH:0]   sum_o
);
    // Conditional (WIDTH+1)-bit add.
    always_comb begin
        if (add_en_i) begin
            sum_o = {1'b0, acc_i} + {1'b0, mcand_i};
        end else begin
            sum_o = {1'b0, acc_i};
        end
    end
endmodule : mult_add_step

// File: rtl/mult_seq_ctrl.sv
// Sequencer and accumulator for the 8-bit shift-and-add multiplier.
// Holds the multiplicand (M) and the high product half (A), and steers the
// external Q shift register: load the multiplier, then one add-and-shift-
// right per clock for WIDTH clocks. Product is {A, Q}.
module mult_seq_ctrl
    import mult_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,   // must equal the Q register width (8)
    parameter int CNT_W = 4    // 2**CNT_W must exceed WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    mult_seq_ctrl_if.slave bus
);
    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]     sum;
    logic [1:0]         q_ctrl;
    logic               q_sinr;
    logic               busy;
    logic               done;

    mult_add_step #(.WIDTH(WIDTH)) u_add_step (
        .acc_i    (a_q),
        .mcand_i  (m_q),
        .add_en_i (bus.q_in[0]),
        .sum_o    (sum)
    );

    // State, accumulator, multiplicand and iteration count registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, regardless of statement order.
            state_q <= state_d;
            a_q     <= a_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and Q-register steering.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the
        // case statement can leave one unassigned and infer a latch.
        state_d = state_q;
        a_d     = a_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        q_ctrl  = CTRL_HOLD;
        q_sinr  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    q_ctrl  = CTRL_LOAD;
                    busy    = 1'b1;
                    m_d     = bus.a_in;
                    a_d     = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                q_ctrl = CTRL_SHR;
                q_sinr = sum[0];
                busy   = 1'b1;
                a_d    = sum[WIDTH:1];
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.q_ctrl  = q_ctrl;
    assign bus.q_sinr  = q_sinr;
    assign bus.q_sinl  = 1'b0;
    assign bus.q_data  = bus.b_in;
    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.product = {a_q, bus.q_in};

endmodule : mult_seq_ctrl

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl with a behavioural model of the
// external 8-bit Q shift register wired to its ctrl/sin/data pins.
module tb_mult_seq_ctrl;
    import mult_seq_ctrl_pkg::*;

    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0]   a;
        logic [WIDTH-1:0]   b;
        logic [2*WIDTH-1:0] exp;
    } vec_t;

    logic clk;
    logic rst;
    logic [WIDTH-1:0] q_reg;
    int n_checks;
    int n_fail;
    vec_t vecs[5];

    mult_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

    mult_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the existing Q shift register (shares the synchronous reset).
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_reg <= '0;
        end else begin
            case (bus.q_ctrl)
                CTRL_LOAD: q_reg <= bus.q_data;
                CTRL_SHR:  q_reg <= {bus.q_sinr, q_reg[WIDTH-1:1]};
                CTRL_SHL:  q_reg <= {q_reg[WIDTH-2:0], bus.q_sinl};
                default:   q_reg <= q_reg;
            endcase
        end
    end
    assign bus.q_in = q_reg;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One full multiply from IDLE; operands are scrambled after acceptance.
    task automatic run_mult(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [2*WIDTH-1:0] exp, input string name);
        int cyc;
        bit shr_ok;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a_in  = a;
        bus.b_in  = b;
        #1;
        check({name, " load ctrl"}, 32'(bus.q_ctrl), 32'(CTRL_LOAD));
        check({name, " load busy"}, 32'(bus.busy), 32'd1);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a_in  = ~a;
        bus.b_in  = ~b;
        #1;
        cyc    = 1;
        shr_ok = 1'b1;
        while (!bus.done && cyc < 20) begin
            if (bus.q_ctrl != CTRL_SHR || !bus.busy) shr_ok = 1'b0;
            @(negedge clk);
            #1;
            cyc++;
        end
        check({name, " done seen"}, 32'(bus.done), 32'd1);
        check({name, " latency"}, 32'(cyc), 32'd9);
        check({name, " shr seq"}, 32'(shr_ok), 32'd1);
        check({name, " done ctrl"}, 32'(bus.q_ctrl), 32'(CTRL_HOLD));
        check({name, " done busy"}, 32'(bus.busy), 32'd0);
        check({name, " product"}, 32'(bus.product), 32'(exp));
        @(negedge clk);
        #1;
        check({name, " done pulse"}, 32'(bus.done), 32'd0);
        check({name, " held"}, 32'(bus.product), 32'(exp));
    endtask

    initial begin
        int done_cnt;
        int done_cyc;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;

        vecs[0] = '{a: 8'd13,   b: 8'd11,   exp: 16'h008F};
        vecs[1] = '{a: 8'd255,  b: 8'd255,  exp: 16'hFE01};
        vecs[2] = '{a: 8'd0,    b: 8'hA5,   exp: 16'h0000};
        vecs[3] = '{a: 8'hC3,   b: 8'h01,   exp: 16'h00C3};
        vecs[4] = '{a: 8'h01,   b: 8'h80,   exp: 16'h0080};

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst done", 32'(bus.done), 32'd0);
        check("rst ctrl", 32'(bus.q_ctrl), 32'(CTRL_HOLD));
        check("rst product", 32'(bus.product), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Table-driven multiplies.
        for (int i = 0; i < 5; i++) begin
            run_mult(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Start pulsed at RUN cycle 3 is ignored.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a_in  = 8'd13;
        bus.b_in  = 8'd11;
        done_cnt  = 0;
        done_cyc  = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            bus.start = (c == 3);
            bus.a_in  = (c == 3) ? 8'd7 : 8'd0;
            bus.b_in  = (c == 3) ? 8'd7 : 8'd0;
            #1;
            if (c == 3) check("ign ctrl", 32'(bus.q_ctrl), 32'(CTRL_SHR));
            if (bus.done) begin
                done_cnt++;
                done_cyc = c;
                check("ign product", 32'(bus.product), 32'h008F);
            end
        end
        check("ign done count", 32'(done_cnt), 32'd1);
        check("ign done cycle", 32'(done_cyc), 32'd9);

        // Reset at RUN cycle 5 aborts the multiply.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a_in  = 8'd13;
        bus.b_in  = 8'd11;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort done", 32'(bus.done), 32'd0);
        check("abort ctrl", 32'(bus.q_ctrl), 32'(CTRL_HOLD));
        check("abort product", 32'(bus.product), 32'd0);
        rst      = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            #1;
            if (bus.done) done_cnt++;
        end
        check("abort no done", 32'(done_cnt), 32'd0);
        run_mult(8'd2, 8'd3, 16'd6, "after abort");

        // Start held high: a new multiply every WIDTH+2 cycles.
        done_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            bus.start = 1'b1;
            bus.a_in  = 8'd16;
            bus.b_in  = 8'd16;
            #1;
            check($sformatf("held busy c%0d", c), 32'(bus.busy), 32'((c % 10) != 9));
            check($sformatf("held done c%0d", c), 32'(bus.done), 32'((c % 10) == 9));
            if (bus.done) begin
                done_cnt++;
                check($sformatf("held product c%0d", c), 32'(bus.product), 32'd256);
            end
        end
        bus.start = 1'b0;
        check("held done count", 32'(done_cnt), 32'd3);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_mult_seq_ctrl
